// File: rtl/ov_frame_gen_pkg.sv
// ov_pkg: shared state encoding, pattern modes, bar colours and RGB565 field widths
// for the ov_frame_gen camera source.
package ov_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFRONT = 3'd4
    } ov_state_e;

    localparam logic [1:0] MODE_BARS  = 2'd0;
    localparam logic [1:0] MODE_GRAD  = 2'd1;
    localparam logic [1:0] MODE_COUNT = 2'd2;
    localparam logic [1:0] MODE_CONST = 2'd3;

    localparam int R_W = 5;
    localparam int G_W = 6;
    localparam int B_W = 5;

    localparam logic [15:0] COL_WHITE   = 16'hFFFF;
    localparam logic [15:0] COL_YELLOW  = 16'hFFE0;
    localparam logic [15:0] COL_CYAN    = 16'h07FF;
    localparam logic [15:0] COL_GREEN   = 16'h07E0;
    localparam logic [15:0] COL_MAGENTA = 16'hF81F;
    localparam logic [15:0] COL_RED     = 16'hF800;
    localparam logic [15:0] COL_BLUE    = 16'h001F;
    localparam logic [15:0] COL_BLACK   = 16'h0000;

    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_colour = COL_WHITE;
            3'd1:    bar_colour = COL_YELLOW;
            3'd2:    bar_colour = COL_CYAN;
            3'd3:    bar_colour = COL_GREEN;
            3'd4:    bar_colour = COL_MAGENTA;
            3'd5:    bar_colour = COL_RED;
            3'd6:    bar_colour = COL_BLUE;
            default: bar_colour = COL_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/ov_frame_gen_if.sv
// Camera-side bus of the OV2640-style source: pixel clock, syncs and pixel byte.
interface ov_frame_gen_if #(
    parameter int DATA_W = 8
);
    logic              PCLK_OV;
    logic              VSYNC_OV;
    logic              HREF_OV;
    logic [DATA_W-1:0] OV_Data_out;

    modport master (output PCLK_OV, VSYNC_OV, HREF_OV, OV_Data_out);
    modport slave  (input  PCLK_OV, VSYNC_OV, HREF_OV, OV_Data_out);
endinterface

// File: rtl/ov_frame_gen_pattern_rom.sv
// ov_pattern_rom: combinational test-pattern byte for (mode, x, y, byte index in line).
// Even byte indices carry the pixel high byte, odd ones the low byte.
module ov_pattern_rom
    import ov_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int X_W      = 10,
    parameter int Y_W      = 9,
    parameter int IDX_W    = 11
) (
    input  logic [1:0]       mode,
    input  logic [X_W-1:0]   x,
    input  logic [Y_W-1:0]   y,
    input  logic [IDX_W-1:0] byte_idx,
    output logic [7:0]       pat_byte
);

    localparam int BAR_W = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;

    logic [15:0] pixel_s;
    int          bar_s;

    // Pixel colour per mode; pixels beyond the eighth bar fall back to black
    always_comb begin
        pixel_s = COL_BLACK;
        bar_s   = int'(x) / BAR_W;
        case (mode)
            MODE_BARS: begin
                if (bar_s < 8) pixel_s = bar_colour(3'(bar_s));
                else           pixel_s = COL_BLACK;
            end
            // Gradient packs x into bits [4:0] and y into [10:5]
            MODE_GRAD:  pixel_s = {{B_W{1'b0}}, G_W'(y), R_W'(x)};
            MODE_CONST: pixel_s = COL_MAGENTA;
            default:    pixel_s = COL_BLACK;
        endcase
    end

    // Byte select; count mode ignores the pixel and emits the byte index
    always_comb begin
        pat_byte = 8'h00;
        if (mode == MODE_COUNT)  pat_byte = 8'(byte_idx);
        else if (byte_idx[0])    pat_byte = pixel_s[7:0];
        else                     pat_byte = pixel_s[15:8];
    end

endmodule

// File: rtl/ov_frame_gen.sv
// ov_frame_gen: parametrised OV2640-style frame source (PCLK/VSYNC/HREF/RGB565 bytes).
// Optional macro OV_FRAME_GEN_FRAME_CNT_EN adds the frame counter and stamps it on pixel (0,0).
module ov_frame_gen
    import ov_pkg::*;
#(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int H_BLANK   = 144,
    parameter int VSYNC_LEN = 4,
    parameter int V_BACK    = 10,
    parameter int V_FRONT   = 10,
    parameter int PCLK_DIV  = 2,
    parameter int DATA_W    = 8
) (
    input  logic                  clk_100mhz,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [1:0]            mode,
    ov_frame_gen_if.master        cam,
    output logic                  frame_done,
    output logic [15:0]           frame_cnt
);

    localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
    localparam int M1       = (VSYNC_LEN > V_BACK) ? VSYNC_LEN : V_BACK;
    localparam int M2       = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int LINE_MAX = (M1 > M2) ? M1 : M2;
    localparam int H_W      = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    localparam int LN_W     = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;
    localparam int X_W      = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int Y_W      = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int DIV_W    = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;

    ov_state_e         state_r, nxt_state_s, follow_s;
    logic [H_W-1:0]    h_r, nxt_h_s;
    logic [LN_W-1:0]   line_r, nxt_line_s;
    logic [DIV_W-1:0]  div_cnt_r;
    logic              pclk_r, vsync_r, href_r, frame_done_r;
    logic [DATA_W-1:0] data_r, data_s;
    logic [1:0]        mode_r;
    logic              fall_tick_s, last_line_s, href_s, done_s, enter_vsync_s;
    logic [7:0]        rom_byte_s, byte_s;

    assign fall_tick_s = pclk_r && (int'(div_cnt_r) == PCLK_DIV - 1);

    // Last-line detection and successor state for the current phase
    always_comb begin
        last_line_s = 1'b0;
        follow_s    = ST_IDLE;
        case (state_r)
            ST_VSYNC:  begin last_line_s = (int'(line_r) == VSYNC_LEN - 1); follow_s = ST_VBACK;  end
            ST_VBACK:  begin last_line_s = (int'(line_r) == V_BACK - 1);    follow_s = ST_ACTIVE; end
            ST_ACTIVE: begin last_line_s = (int'(line_r) == V_ACTIVE - 1);  follow_s = ST_VFRONT; end
            ST_VFRONT: begin
                last_line_s = (int'(line_r) == V_FRONT - 1);
                if (enable) follow_s = ST_VSYNC;
                else        follow_s = ST_IDLE;
            end
            default:   begin last_line_s = 1'b0; follow_s = ST_IDLE; end
        endcase
    end

    // Position of the PCLK period that starts at the coming fall tick
    always_comb begin
        nxt_state_s = state_r;
        nxt_line_s  = line_r;
        nxt_h_s     = h_r + H_W'(1);
        if (state_r == ST_IDLE) begin
            nxt_h_s    = {H_W{1'b0}};
            nxt_line_s = {LN_W{1'b0}};
            if (enable) nxt_state_s = ST_VSYNC;
            else        nxt_state_s = ST_IDLE;
        end else if (int'(h_r) == LINE_LEN - 1) begin
            nxt_h_s = {H_W{1'b0}};
            if (last_line_s) begin
                nxt_line_s  = {LN_W{1'b0}};
                nxt_state_s = follow_s;
            end else begin
                nxt_line_s  = line_r + LN_W'(1);
            end
        end else begin
            nxt_h_s = h_r + H_W'(1);
        end
    end

    assign href_s        = (nxt_state_s == ST_ACTIVE) && (int'(nxt_h_s) < 2 * H_ACTIVE);
    assign done_s        = (nxt_state_s == ST_VFRONT) && (int'(nxt_line_s) == V_FRONT - 1)
                           && (int'(nxt_h_s) == LINE_LEN - 1);
    assign enter_vsync_s = (nxt_state_s == ST_VSYNC) && (state_r != ST_VSYNC);

    ov_pattern_rom #(
        .H_ACTIVE (H_ACTIVE),
        .X_W      (X_W),
        .Y_W      (Y_W),
        .IDX_W    (H_W)
    ) u_rom (
        .mode     (mode_r),
        .x        (X_W'(nxt_h_s >> 1)),
        .y        (Y_W'(nxt_line_s)),
        .byte_idx (nxt_h_s),
        .pat_byte (rom_byte_s)
    );

`ifdef OV_FRAME_GEN_FRAME_CNT_EN
    logic [15:0] frame_cnt_r;

    // Completed-frame counter, wraps at 16 bits
    always_ff @(posedge clk_100mhz) begin
        if (rst)                         frame_cnt_r <= 16'd0;
        else if (fall_tick_s && done_s)  frame_cnt_r <= frame_cnt_r + 16'd1;
        else                             frame_cnt_r <= frame_cnt_r;
    end

    assign frame_cnt = frame_cnt_r;

    // Pixel (0,0) carries the frame count instead of the pattern
    always_comb begin
        byte_s = rom_byte_s;
        if ((nxt_state_s == ST_ACTIVE) && (nxt_line_s == {LN_W{1'b0}}) && (int'(nxt_h_s) < 2)) begin
            if (nxt_h_s[0]) byte_s = frame_cnt_r[7:0];
            else            byte_s = frame_cnt_r[15:8];
        end else begin
            byte_s = rom_byte_s;
        end
    end
`else
    assign frame_cnt = 16'd0;
    assign byte_s    = rom_byte_s;
`endif

    // Pattern bytes are MSB-aligned on wider buses; blanking forces zero
    always_comb begin
        data_s = {DATA_W{1'b0}};
        if (href_s) data_s = DATA_W'(byte_s) << (DATA_W - 8);
        else        data_s = {DATA_W{1'b0}};
    end

    // Free-running PCLK divider plus fall-tick update of FSM, counters and outputs
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            div_cnt_r    <= {DIV_W{1'b0}};
            pclk_r       <= 1'b0;
            state_r      <= ST_IDLE;
            h_r          <= {H_W{1'b0}};
            line_r       <= {LN_W{1'b0}};
            mode_r       <= 2'd0;
            vsync_r      <= 1'b0;
            href_r       <= 1'b0;
            data_r       <= {DATA_W{1'b0}};
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            if (int'(div_cnt_r) == PCLK_DIV - 1) begin
                div_cnt_r <= {DIV_W{1'b0}};
                pclk_r    <= ~pclk_r;
            end else begin
                div_cnt_r <= div_cnt_r + DIV_W'(1);
            end
            if (fall_tick_s) begin
                state_r      <= nxt_state_s;
                h_r          <= nxt_h_s;
                line_r       <= nxt_line_s;
                vsync_r      <= (nxt_state_s == ST_VSYNC);
                href_r       <= href_s;
                data_r       <= data_s;
                frame_done_r <= done_s;
                if (enter_vsync_s) mode_r <= mode;
            end
        end
    end

    assign cam.PCLK_OV     = pclk_r;
    assign cam.VSYNC_OV    = vsync_r;
    assign cam.HREF_OV     = href_r;
    assign cam.OV_Data_out = data_r;
    assign frame_done      = frame_done_r;

endmodule

// File: tb/tb_ov_frame_gen.sv
// Scoreboard bench for ov_frame_gen on a small 8x4 geometry (L=20, 140-PCLK frame).
module tb_ov_frame_gen;
    import ov_pkg::*;

    localparam int LINE_LEN  = 20;
    localparam int FRAME_PER = 140;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        frame_done;
    logic [15:0] frame_cnt;

    int n_checks = 0;
    int n_fails  = 0;
    int unsigned cyc = 0;
    int unsigned fd_times[$];
    logic [9:0]  exp_q[$];
    int          frame_no = 0;

    ov_frame_gen_if #(.DATA_W(8)) cam();

    ov_frame_gen #(
        .H_ACTIVE(8), .V_ACTIVE(4), .H_BLANK(4), .VSYNC_LEN(1),
        .V_BACK(1), .V_FRONT(1), .PCLK_DIV(1), .DATA_W(8)
    ) dut (
        .clk_100mhz (clk),
        .rst        (rst),
        .enable     (enable),
        .mode       (mode),
        .cam        (cam),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (frame_done) fd_times.push_back(cyc);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected {VSYNC, HREF, data} for PCLK period p of a frame
    function automatic logic [9:0] exp_period(input logic [1:0] m, input int p, input logic [15:0] fcnt);
        int line, h, x, y;
        logic [15:0] pix;
        logic [7:0]  b;
        line = p / LINE_LEN;
        h    = p % LINE_LEN;
        if (line < 1) return 10'h200;
        if (line < 2 || line > 5 || h >= 16) return 10'h000;
        y = line - 2;
        x = h / 2;
        case (x)
            0: pix = 16'hFFFF; 1: pix = 16'hFFE0; 2: pix = 16'h07FF; 3: pix = 16'h07E0;
            4: pix = 16'hF81F; 5: pix = 16'hF800; 6: pix = 16'h001F; default: pix = 16'h0000;
        endcase
        if (m == 2'd1) pix = 16'(y * 32 + x);
        if (m == 2'd3) pix = 16'hF81F;
        b = (h % 2 == 1) ? pix[7:0] : pix[15:8];
        if (m == 2'd2) b = 8'(h);
`ifdef OV_FRAME_GEN_FRAME_CNT_EN
        if (x == 0 && y == 0) b = (h == 1) ? fcnt[7:0] : fcnt[15:8];
`endif
        return {2'b01, b};
    endfunction

    task automatic next_period();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cam.PCLK_OV && n < 8);
        if (!cam.PCLK_OV) check_eq("pclk_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_frame_start();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cam.VSYNC_OV && n < 600);
        if (!cam.VSYNC_OV) check_eq("vsync_timeout", 32'd0, 32'd1);
    endtask

    // Push a whole frame of expectations, then pop one per PCLK period
    task automatic check_frame(input logic [1:0] m, input logic [15:0] fcnt,
                               input int act_at, input logic [1:0] act_mode, input logic act_en);
        logic [9:0] got, exp;
        for (int p = 0; p < FRAME_PER; p++) exp_q.push_back(exp_period(m, p, fcnt));
        for (int p = 0; p < FRAME_PER; p++) begin
            if (p == act_at) begin
                mode   = act_mode;
                enable = act_en;
            end
            next_period();
            got = {cam.VSYNC_OV, cam.HREF_OV, cam.OV_Data_out};
            exp = exp_q.pop_front();
            check_eq($sformatf("f%0d_p%0d", frame_no, p), 32'(got), 32'(exp));
        end
        frame_no++;
    endtask

    initial begin
        int n, bad;
        logic [15:0] cnt_exp;

        enable = 1'b1;
        mode   = 2'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_pclk",  32'(cam.PCLK_OV),     32'd0);
        check_eq("rst_vsync", 32'(cam.VSYNC_OV),    32'd0);
        check_eq("rst_href",  32'(cam.HREF_OV),     32'd0);
        check_eq("rst_data",  32'(cam.OV_Data_out), 32'd0);
        check_eq("rst_done",  32'(frame_done),      32'd0);
        check_eq("rst_fcnt",  32'(frame_cnt),       32'd0);

        rst = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cam.VSYNC_OV && n < 20);
        check_eq("vsync_lat", 32'(n), 32'd2);

        check_frame(2'd0, 16'd0, 60, 2'd2, 1'b1);
        check_frame(2'd2, 16'd1, -1, 2'd2, 1'b1);
        check_frame(2'd2, 16'd2, 10, 2'd1, 1'b1);
`ifdef OV_FRAME_GEN_FRAME_CNT_EN
        cnt_exp = 16'd3;
`else
        cnt_exp = 16'd0;
`endif
        check_eq("fcnt_after3", 32'(frame_cnt), 32'(cnt_exp));
        check_frame(2'd1, 16'd3, 70, 2'd1, 1'b0);

        check_eq("fd_count", 32'(fd_times.size()), 32'd4);
        if (fd_times.size() >= 4)
            for (int i = 1; i < 4; i++)
                check_eq($sformatf("fd_gap%0d", i), 32'(fd_times[i] - fd_times[i-1]), 32'd280);

        bad = 0;
        repeat (40) begin
            next_period();
            if (cam.VSYNC_OV || cam.HREF_OV || (cam.OV_Data_out != 8'h00)) bad++;
        end
        check_eq("idle_quiet", 32'(bad), 32'd0);
        check_eq("idle_no_fd", 32'(fd_times.size()), 32'd4);

        mode   = 2'd3;
        enable = 1'b1;
        wait_frame_start();
        for (int p = 0; p < 85; p++) next_period();
        check_eq("pre_rst", 32'({cam.VSYNC_OV, cam.HREF_OV, cam.OV_Data_out}),
                 32'(exp_period(2'd3, 84, 16'd4)));
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_pclk",  32'(cam.PCLK_OV),     32'd0);
        check_eq("mid_rst_vsync", 32'(cam.VSYNC_OV),    32'd0);
        check_eq("mid_rst_href",  32'(cam.HREF_OV),     32'd0);
        check_eq("mid_rst_data",  32'(cam.OV_Data_out), 32'd0);
        check_eq("mid_rst_fcnt",  32'(frame_cnt),       32'd0);
        rst = 1'b0;

        wait_frame_start();
        check_frame(2'd3, 16'd0, -1, 2'd3, 1'b1);
`ifdef OV_FRAME_GEN_FRAME_CNT_EN
        cnt_exp = 16'd1;
`else
        cnt_exp = 16'd0;
`endif
        check_eq("fcnt_after_rst", 32'(frame_cnt), 32'(cnt_exp));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
